// File: rtl/imm_gen_pipe.sv
// Multi-lane RV immediate generator: each lane decodes its format from the opcode and
// produces a sign-extended immediate, held in a registered 2-entry main/skid buffer.
module imm_gen_pipe #(
    parameter int LANES = 2,
    parameter int XLEN  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*32-1:0]     instr,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*XLEN-1:0]   imm_ext,
    output logic [LANES*3-1:0]      imm_fmt
);

    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_S    = 3'd1;
    localparam logic [2:0] FMT_B    = 3'd2;
    localparam logic [2:0] FMT_U    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
    localparam logic [2:0] FMT_NONE = 3'd7;

    function automatic logic [2:0] fmt_of(input logic [6:0] opcode);
        logic [2:0] f;
        case (opcode)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: f = FMT_I;
            7'b0100011:                                     f = FMT_S;
            7'b1100011:                                     f = FMT_B;
            7'b0110111, 7'b0010111:                         f = FMT_U;
            7'b1101111:                                     f = FMT_J;
            default:                                        f = FMT_NONE;
        endcase
        return f;
    endfunction

    // Build the 32-bit immediate, then widen through a signed cast so XLEN=64 sign-extends.
    function automatic logic [XLEN-1:0] imm_of(input logic [31:0] ins, input logic [2:0] fmt);
        logic signed [31:0] v;
        logic               s;
        s = ins[31];
        case (fmt)
            FMT_I:   v = {{20{s}}, ins[31:20]};
            FMT_S:   v = {{20{s}}, ins[31:25], ins[11:7]};
            FMT_B:   v = {{19{s}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   v = {ins[31:12], 12'b0};
            FMT_J:   v = {{11{s}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: v = 32'sd0;
        endcase
        return XLEN'(v);
    endfunction

    logic [LANES*XLEN-1:0] w_imm;
    logic [LANES*3-1:0]    w_fmt;
    logic                  w_accept;
    logic                  w_pop;

    logic                  r_main_valid;
    logic                  r_skid_valid;
    logic [LANES*XLEN-1:0] r_main_imm;
    logic [LANES*XLEN-1:0] r_skid_imm;
    logic [LANES*3-1:0]    r_main_fmt;
    logic [LANES*3-1:0]    r_skid_fmt;

    // Per-lane decode of the incoming bundle.
    always_comb begin
        w_imm = '0;
        w_fmt = '0;
        for (int i = 0; i < LANES; i++) begin
            w_fmt[i*3 +: 3]       = fmt_of(instr[i*32 +: 7]);
            w_imm[i*XLEN +: XLEN] = imm_of(instr[i*32 +: 32], fmt_of(instr[i*32 +: 7]));
        end
    end

    assign w_accept  = in_valid && !r_skid_valid;
    assign w_pop     = r_main_valid && out_ready;

    assign in_ready  = !r_skid_valid;
    assign out_valid = r_main_valid;
    assign imm_ext   = r_main_imm;
    assign imm_fmt   = r_main_fmt;

    // Main/skid buffer; an accept together with a pop never sees a full skid since in_ready is low then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_imm   <= '0;
            r_skid_imm   <= '0;
            r_main_fmt   <= '0;
            r_skid_fmt   <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            case ({w_accept, w_pop})
                2'b10: begin
                    if (!r_main_valid) begin
                        r_main_valid <= 1'b1;
                        r_main_imm   <= w_imm;
                        r_main_fmt   <= w_fmt;
                    end else begin
                        r_skid_valid <= 1'b1;
                        r_skid_imm   <= w_imm;
                        r_skid_fmt   <= w_fmt;
                    end
                end
                2'b01: begin
                    if (r_skid_valid) begin
                        r_main_imm   <= r_skid_imm;
                        r_main_fmt   <= r_skid_fmt;
                        r_skid_valid <= 1'b0;
                    end else begin
                        r_main_valid <= 1'b0;
                    end
                end
                2'b11: begin
                    r_main_imm <= w_imm;
                    r_main_fmt <= w_fmt;
                end
                default: begin
                    r_main_valid <= r_main_valid;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are
// compared against a queue-based occupancy model with an arithmetic immediate reference.
module tb_imm_gen_pipe;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         flush;
    logic         out_ready;
    logic [63:0]  instr;
    logic         in_ready32, out_valid32, in_ready64, out_valid64;
    logic [63:0]  imm32;
    logic [127:0] imm64;
    logic [5:0]   fmt32, fmt64;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [5:0]   fmt;
        logic [127:0] imm;
    } bundle_t;

    typedef struct {
        logic [63:0]  ins;
        logic [127:0] imm;
        logic [5:0]   fmt;
    } vec_t;

    bundle_t     q[$];
    logic [63:0] popped[$];
    logic        last_acc;

    imm_gen_pipe #(.LANES(2), .XLEN(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .flush(flush), .out_valid(out_valid32), .out_ready(out_ready),
        .imm_ext(imm32), .imm_fmt(fmt32)
    );

    imm_gen_pipe #(.LANES(2), .XLEN(64)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .flush(flush), .out_valid(out_valid64), .out_ready(out_ready),
        .imm_ext(imm64), .imm_fmt(fmt64)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_fmt(input logic [31:0] ins);
        case (ins[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: return 3'd0;
            7'b0100011:                                     return 3'd1;
            7'b1100011:                                     return 3'd2;
            7'b0110111, 7'b0010111:                         return 3'd3;
            7'b1101111:                                     return 3'd4;
            default:                                        return 3'd7;
        endcase
    endfunction

    function automatic longint field(input logic [31:0] ins, input int hi, input int lo);
        longint x;
        x = longint'({32'd0, ins});
        return (x >> lo) % (longint'(1) << (hi - lo + 1));
    endfunction

    function automatic longint sext(input longint v, input int bits);
        if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
        return v;
    endfunction

    function automatic longint ref_imm(input logic [31:0] ins);
        case (ref_fmt(ins))
            3'd0: return sext(field(ins, 31, 20), 12);
            3'd1: return sext(field(ins, 31, 25) * 32 + field(ins, 11, 7), 12);
            3'd2: return sext(field(ins, 31, 31) * 4096 + field(ins, 7, 7) * 2048
                              + field(ins, 30, 25) * 32 + field(ins, 11, 8) * 2, 13);
            3'd3: return sext(field(ins, 31, 12) * 4096, 32);
            3'd4: return sext(field(ins, 31, 31) * 1048576 + field(ins, 19, 12) * 4096
                              + field(ins, 20, 20) * 2048 + field(ins, 30, 21) * 2, 21);
            default: return 64'sd0;
        endcase
    endfunction

    function automatic bundle_t make_bundle(input logic [63:0] ins);
        bundle_t b;
        for (int l = 0; l < 2; l++) begin
            b.fmt[l*3 +: 3]  = ref_fmt(ins[l*32 +: 32]);
            b.imm[l*64 +: 64] = ref_imm(ins[l*32 +: 32]);
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
        chk("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
        chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
        chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
        if (q.size() > 0) begin
            for (int l = 0; l < 2; l++) begin
                chk($sformatf("imm64_lane%0d", l), imm64[l*64 +: 64], q[0].imm[l*64 +: 64]);
                chk($sformatf("imm32_lane%0d", l), 64'(imm32[l*32 +: 32]), 64'(q[0].imm[l*64 +: 32]));
                chk($sformatf("fmt32_lane%0d", l), 64'(fmt32[l*3 +: 3]), 64'(q[0].fmt[l*3 +: 3]));
                chk($sformatf("fmt64_lane%0d", l), 64'(fmt64[l*3 +: 3]), 64'(q[0].fmt[l*3 +: 3]));
            end
        end
    endtask

    // Called at a negedge: drive inputs, advance model across the posedge, check at next negedge.
    task automatic cycle(input logic v, input logic [63:0] ins, input logic ordy, input logic fl);
        int      occ;
        bundle_t nb;
        in_valid  = v;
        instr     = ins;
        out_ready = ordy;
        flush     = fl;
        occ       = q.size();
        nb        = make_bundle(ins);
        last_acc  = v && (occ < 2) && !fl;
        if (out_valid32 && ordy && !fl) popped.push_back(imm32);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (ordy && occ > 0) void'(q.pop_front());
            if (v && occ < 2) q.push_back(nb);
        end
        @(negedge clk);
        check_outputs();
    endtask

    vec_t        vt[5];
    logic [63:0] bp[4];
    logic [31:0] opcodes[10];

    initial begin
        vt[0] = '{64'hFE112E23_FFF00093, {64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF}, {3'd1, 3'd0}};
        vt[1] = '{64'h001000EF_FE000CE3, {64'h0000_0000_0000_0800, 64'hFFFF_FFFF_FFFF_FFF8}, {3'd4, 3'd2}};
        vt[2] = '{64'h800002B7_123452B7, {64'hFFFF_FFFF_8000_0000, 64'h0000_0000_1234_5000}, {3'd3, 3'd3}};
        vt[3] = '{64'hFFF00093_002081B3, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, {3'd0, 3'd7}};
        vt[4] = '{64'h00112223_002081B3, {64'h0000_0000_0000_0004, 64'h0}, {3'd1, 3'd7}};
        opcodes = '{32'h13, 32'h03, 32'h67, 32'h73, 32'h23, 32'h63, 32'h37, 32'h17, 32'h6F, 32'h33};

        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; instr = 64'd0;
        #2;
        chk("reset_out_valid", 64'(out_valid32), 64'd0);
        chk("reset_in_ready", 64'(in_ready32), 64'd1);
        chk("reset_imm32", imm32, 64'd0);
        chk("reset_imm64_hi", imm64[127:64], 64'd0);
        chk("reset_fmt", 64'({fmt32, fmt64}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_outputs();

        // Directed single-beat vectors
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, vt[k].ins, 1'b1, 1'b0);
            for (int l = 0; l < 2; l++) begin
                chk($sformatf("vec%0d_imm64_l%0d", k, l), imm64[l*64 +: 64], vt[k].imm[l*64 +: 64]);
                chk($sformatf("vec%0d_imm32_l%0d", k, l), 64'(imm32[l*32 +: 32]), 64'(vt[k].imm[l*64 +: 32]));
                chk($sformatf("vec%0d_fmt32_l%0d", k, l), 64'(fmt32[l*3 +: 3]), 64'(vt[k].fmt[l*3 +: 3]));
                chk($sformatf("vec%0d_fmt64_l%0d", k, l), 64'(fmt64[l*3 +: 3]), 64'(vt[k].fmt[l*3 +: 3]));
            end
        end
        cycle(1'b0, 64'd0, 1'b1, 1'b0);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);

        // Back-pressure: A,B,C,D with out_ready low for three cycles
        bp = '{vt[0].ins, vt[1].ins, vt[2].ins, vt[4].ins};
        popped.delete();
        begin
            int idx = 0;
            for (int cyc = 0; cyc < 20 && (idx < 4 || q.size() > 0); cyc++) begin
                cycle(idx < 4, bp[idx < 4 ? idx : 0], cyc >= 3, 1'b0);
                if (last_acc) begin
                    if (idx == 1) chk("in_ready_after_B", 64'(in_ready32), 64'd0);
                    idx++;
                end
                if (cyc == 2) chk("stall_holds_A", imm32, {vt[0].imm[95:64], vt[0].imm[31:0]});
                if (cyc == 3) chk("in_ready_after_first_pop", 64'(in_ready32), 64'd1);
            end
            chk("bp_all_accepted", 64'(idx), 64'd4);
        end
        chk("bp_pop_count", 64'(popped.size()), 64'd4);
        for (int k = 0; k < 4 && k < popped.size(); k++) begin
            bundle_t e;
            e = make_bundle(bp[k]);
            chk($sformatf("bp_order_%0d", k), popped[k], {e.imm[95:64], e.imm[31:0]});
        end

        // Flush with both entries full and bundle E presented
        cycle(1'b1, vt[0].ins, 1'b0, 1'b0);
        cycle(1'b1, vt[1].ins, 1'b0, 1'b0);
        chk("full_in_ready", 64'(in_ready32), 64'd0);
        popped.delete();
        cycle(1'b1, vt[2].ins, 1'b0, 1'b1);
        chk("flush_out_valid", 64'(out_valid32), 64'd0);
        chk("flush_in_ready", 64'(in_ready32), 64'd1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 64'd0, 1'b1, 1'b0);
        chk("flush_nothing_popped", 64'(popped.size()), 64'd0);

        // Asynchronous reset mid-stream
        cycle(1'b1, vt[1].ins, 1'b0, 1'b0);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("async_reset_out_valid", 64'(out_valid32), 64'd0);
        chk("async_reset_out_valid64", 64'(out_valid64), 64'd0);
        chk("async_reset_imm32", imm32, 64'd0);
        chk("async_reset_fmt", 64'(fmt32), 64'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_outputs();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [63:0] ri;
            for (int l = 0; l < 2; l++) begin
                ri[l*32 +: 32] = {$urandom() & 32'hFFFF_FF80} | opcodes[$urandom_range(0, 9)];
                if ($urandom_range(0, 9) == 0) ri[l*32 +: 32] = $urandom();
            end
            cycle($urandom_range(0, 1) == 1, ri, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
